// File: rtl/msi_cache_ctrl.sv
// Direct-mapped write-back cache controller with per-line MSI coherence.
// One processor port, one snooping bus port; snoop effects are applied after local updates each cycle.
module msi_cache_ctrl #(
    parameter  int ADDR_W     = 8,
    parameter  int LINE_BYTES = 4,
    parameter  int SETS       = 4,
    localparam int LINE_W     = 8 * LINE_BYTES,
    localparam int OFF_W      = $clog2(LINE_BYTES),
    localparam int IDX_W      = $clog2(SETS),
    localparam int TAG_W      = ADDR_W - OFF_W - IDX_W,
    localparam int LADDR_W    = ADDR_W - OFF_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               p_req,
    input  logic               p_we,
    input  logic [ADDR_W-1:0]  p_addr,
    input  logic [7:0]         p_wdata,
    output logic [7:0]         p_rdata,
    output logic               p_ready,
    output logic               bus_req,
    input  logic               bus_gnt,
    output logic [1:0]         bus_cmd,
    output logic [LADDR_W-1:0] bus_addr,
    output logic [LINE_W-1:0]  bus_wdata,
    input  logic [LINE_W-1:0]  bus_rdata,
    input  logic               bus_ack,
    input  logic               snp_valid,
    input  logic [1:0]         snp_cmd,
    input  logic [LADDR_W-1:0] snp_addr,
    output logic               snp_hit,
    output logic               snp_supply,
    output logic [LINE_W-1:0]  snp_data
);

    localparam logic [1:0] CMD_GETS = 2'b00;
    localparam logic [1:0] CMD_GETM = 2'b01;
    localparam logic [1:0] CMD_UPG  = 2'b10;
    localparam logic [1:0] CMD_PUTM = 2'b11;

    typedef enum logic [1:0] {ST_I = 2'b00, ST_S = 2'b10, ST_M = 2'b11} line_st_t;
    // IDLE accept | WB_REQ PutM victim | FILL_REQ GetS/GetM | UPG_REQ Upg | DONE p_ready pulse
    typedef enum logic [2:0] {IDLE, WB_REQ, FILL_REQ, UPG_REQ, DONE} fsm_t;

    fsm_t               state_q;
    logic               p_ready_q, bus_req_q, snp_hit_q, snp_supply_q;
    logic [7:0]         p_rdata_q;
    logic [1:0]         bus_cmd_q;
    logic [LADDR_W-1:0] bus_addr_q;
    logic [LINE_W-1:0]  bus_wdata_q, snp_data_q;

    line_st_t           st_q   [SETS];
    line_st_t           st_d   [SETS];
    logic [TAG_W-1:0]   tag_q  [SETS];
    logic [TAG_W-1:0]   tag_d  [SETS];
    logic [LINE_W-1:0]  data_q [SETS];
    logic [LINE_W-1:0]  data_d [SETS];

    logic [IDX_W-1:0]   idx, s_idx;
    logic [TAG_W-1:0]   p_tag, s_tag;
    logic [OFF_W-1:0]   off;
    logic [LADDR_W-1:0] laddr;
    logic               hit, own_ack, snp_stall, do_hit_wr;
    logic               snp_match, snp_sup;
    logic [LINE_W-1:0]  snp_line;
    logic [7:0]         rd_byte;

    function automatic logic [LINE_W-1:0] put_byte(input logic [LINE_W-1:0] line,
                                                   input logic [OFF_W-1:0]  o,
                                                   input logic [7:0]        b);
        logic [LINE_W-1:0] r;
        r = line;
        r[{o, 3'b000} +: 8] = b;
        return r;
    endfunction

    assign idx       = p_addr[OFF_W +: IDX_W];
    assign p_tag     = p_addr[ADDR_W-1 -: TAG_W];
    assign off       = p_addr[OFF_W-1:0];
    assign laddr     = p_addr[ADDR_W-1:OFF_W];
    assign s_idx     = snp_addr[IDX_W-1:0];
    assign s_tag     = snp_addr[LADDR_W-1:IDX_W];
    assign hit       = (st_q[idx] != ST_I) && (tag_q[idx] == p_tag);
    assign own_ack   = bus_ack && bus_gnt && bus_req_q;
    // A snoop to the requested set holds off acceptance so the decision never sees a stale state.
    assign snp_stall = snp_valid && (s_idx == idx);
    assign do_hit_wr = (state_q == IDLE) && p_req && !snp_stall && p_we && hit && (st_q[idx] == ST_M);

    always_comb begin
        st_d   = st_q;
        tag_d  = tag_q;
        data_d = data_q;
        if (do_hit_wr)
            data_d[idx] = put_byte(data_q[idx], off, p_wdata);
        if (state_q == WB_REQ && own_ack)
            st_d[idx] = ST_I;
        if (state_q == FILL_REQ && own_ack) begin
            tag_d[idx]  = p_tag;
            data_d[idx] = p_we ? put_byte(bus_rdata, off, p_wdata) : bus_rdata;
            st_d[idx]   = p_we ? ST_M : ST_S;
        end
        if (state_q == UPG_REQ && own_ack) begin
            st_d[idx]   = ST_M;
            data_d[idx] = put_byte(data_q[idx], off, p_wdata);
        end
        rd_byte = data_d[idx][{off, 3'b000} +: 8];

        // Snoop sees the post-local-update line, which orders our own ack first.
        snp_line  = data_d[s_idx];
        snp_match = snp_valid && (st_d[s_idx] != ST_I) && (tag_d[s_idx] == s_tag);
        snp_sup   = snp_match && (st_d[s_idx] == ST_M) &&
                    (snp_cmd == CMD_GETS || snp_cmd == CMD_GETM);
        if (snp_match) begin
            case (snp_cmd)
                CMD_GETS: if (st_d[s_idx] == ST_M) st_d[s_idx] = ST_S;
                CMD_GETM: st_d[s_idx] = ST_I;
                CMD_UPG:  if (st_d[s_idx] == ST_S) st_d[s_idx] = ST_I;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SETS; i++) st_q[i] <= ST_I;
        end else begin
            for (int i = 0; i < SETS; i++) st_q[i] <= st_d[i];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < SETS; i++) begin
            tag_q[i]  <= tag_d[i];
            data_q[i] <= data_d[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            p_ready_q    <= 1'b0;
            p_rdata_q    <= '0;
            bus_req_q    <= 1'b0;
            bus_cmd_q    <= '0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            snp_hit_q    <= 1'b0;
            snp_supply_q <= 1'b0;
            snp_data_q   <= '0;
        end else begin
            p_ready_q    <= 1'b0;
            snp_hit_q    <= snp_match;
            snp_supply_q <= snp_sup;
            snp_data_q   <= snp_sup ? snp_line : '0;
            case (state_q)
                IDLE: begin
                    if (p_req && !snp_stall) begin
                        if (hit && (!p_we || st_q[idx] == ST_M)) begin
                            p_ready_q <= 1'b1;
                            p_rdata_q <= rd_byte;
                            state_q   <= DONE;
                        end else if (hit) begin
                            state_q     <= UPG_REQ;
                            bus_req_q   <= 1'b1;
                            bus_cmd_q   <= CMD_UPG;
                            bus_addr_q  <= laddr;
                            bus_wdata_q <= '0;
                        end else if (st_q[idx] == ST_M) begin
                            state_q     <= WB_REQ;
                            bus_req_q   <= 1'b1;
                            bus_cmd_q   <= CMD_PUTM;
                            bus_addr_q  <= {tag_q[idx], idx};
                            bus_wdata_q <= data_q[idx];
                        end else begin
                            state_q     <= FILL_REQ;
                            bus_req_q   <= 1'b1;
                            bus_cmd_q   <= p_we ? CMD_GETM : CMD_GETS;
                            bus_addr_q  <= laddr;
                            bus_wdata_q <= '0;
                        end
                    end
                end
                WB_REQ: begin
                    // Either our PutM completed or a snoop took the victim away.
                    if (own_ack || st_d[idx] != ST_M) begin
                        bus_req_q <= 1'b0;
                        state_q   <= FILL_REQ;
                    end
                end
                FILL_REQ: begin
                    if (own_ack) begin
                        bus_req_q <= 1'b0;
                        p_ready_q <= 1'b1;
                        p_rdata_q <= rd_byte;
                        state_q   <= DONE;
                    end else if (!bus_req_q) begin
                        bus_req_q   <= 1'b1;
                        bus_cmd_q   <= p_we ? CMD_GETM : CMD_GETS;
                        bus_addr_q  <= laddr;
                        bus_wdata_q <= '0;
                    end
                end
                UPG_REQ: begin
                    if (own_ack) begin
                        bus_req_q <= 1'b0;
                        p_ready_q <= 1'b1;
                        p_rdata_q <= rd_byte;
                        state_q   <= DONE;
                    end else if (st_d[idx] == ST_I) begin
                        bus_cmd_q <= CMD_GETM;
                        state_q   <= FILL_REQ;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign p_ready    = p_ready_q;
    assign p_rdata    = p_rdata_q;
    assign bus_req    = bus_req_q;
    assign bus_cmd    = bus_cmd_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign snp_hit    = snp_hit_q;
    assign snp_supply = snp_supply_q;
    assign snp_data   = snp_data_q;

endmodule
